// File: rtl/sdp_y_cfg_triosy_rcv.sv
// sdp_y_cfg_triosy_rcv: receive side of the SDP Y-core triosy config handshake.
// Each triosy_lz strobe and its data word are captured into an in-order FIFO
// of DEPTH entries, which drains through out_vld/out_rdy. rcv_stall holds the
// producer off while the FIFO is full.
// Optional feature macro: SDP_Y_CFG_TRIOSY_RCV_OVF_ERR_EN builds a sticky
// rcv_ovf_err flag for strobes presented against stall; otherwise it is tied 0.
module sdp_y_cfg_triosy_rcv #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 4
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          triosy_lz,
  input  logic [DW-1:0] triosy_dat,
  output logic          rcv_stall,
  output logic          out_vld,
  output logic [DW-1:0] out_dat,
  input  logic          out_rdy,
  output logic [CW-1:0] rcv_level,
  output logic          rcv_ovf_err
);

  localparam int unsigned    PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_e;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  occ_e          r_state;

  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  occ_e          w_state_nxt;

  // Occupancy state is kept alongside the count so stall/valid decode from a
  // registered encoding rather than a CW-wide compare.
  assign out_vld   = (r_state != ST_EMPTY);
  assign rcv_stall = (r_state == ST_FULL);
  assign rcv_level = r_count;
  assign out_dat   = out_vld ? r_mem[r_rd_ptr] : '0;

  assign w_push = triosy_lz & ~rcv_stall;
  assign w_pop  = out_vld & out_rdy;

  // Next pointers, count and occupancy state.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_state_nxt  = r_state;

    if (w_push) begin
      w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
    end
    if (w_pop) begin
      w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
    end

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase

    if (w_count_nxt == '0) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_count_nxt == FULL_CNT) begin
      w_state_nxt = ST_FULL;
    end else begin
      w_state_nxt = ST_PARTIAL;
    end
  end

  // Control state register; reset discards every entry.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= ST_EMPTY;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_state  <= w_state_nxt;
    end
  end

  // Storage write; the array itself is not reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= triosy_dat;
    end
  end

`ifdef SDP_Y_CFG_TRIOSY_RCV_OVF_ERR_EN
  logic r_ovf_err;

  // Sticky flag for any strobe presented while stalled; cleared only by reset.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_ovf_err <= 1'b0;
    end else if (triosy_lz & rcv_stall) begin
      r_ovf_err <= 1'b1;
    end
  end

  assign rcv_ovf_err = r_ovf_err;
`else
  assign rcv_ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdp_y_cfg_triosy_rcv.sv
// Testbench for sdp_y_cfg_triosy_rcv: a DEPTH=2 instance driven by a vector
// table and scoreboarded sequences, and a DEPTH=3 instance with random out_rdy.
module tb_sdp_y_cfg_triosy_rcv;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
`ifdef SDP_Y_CFG_TRIOSY_RCV_OVF_ERR_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          lz2  = 1'b0;
  logic [DW-1:0] dat2 = '0;
  logic          rdy2 = 1'b0;
  logic          stall2, vld2, ovf2;
  logic [DW-1:0] odat2;
  logic [CW-1:0] lvl2;

  logic          lz3  = 1'b0;
  logic [DW-1:0] dat3 = '0;
  logic          rdy3 = 1'b0;
  logic          stall3, vld3, ovf3;
  logic [DW-1:0] odat3;
  logic [CW-1:0] lvl3;

  sdp_y_cfg_triosy_rcv #(.DW(DW), .DEPTH(2), .CW(CW)) u_dut2 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .triosy_lz       (lz2),
    .triosy_dat      (dat2),
    .rcv_stall       (stall2),
    .out_vld         (vld2),
    .out_dat         (odat2),
    .out_rdy         (rdy2),
    .rcv_level       (lvl2),
    .rcv_ovf_err     (ovf2)
  );

  sdp_y_cfg_triosy_rcv #(.DW(DW), .DEPTH(3), .CW(CW)) u_dut3 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .triosy_lz       (lz3),
    .triosy_dat      (dat3),
    .rcv_stall       (stall3),
    .out_vld         (vld3),
    .out_dat         (odat3),
    .out_rdy         (rdy3),
    .rcv_level       (lvl3),
    .rcv_ovf_err     (ovf3)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q2[$];
  logic [DW-1:0] q3[$];

  typedef struct {
    logic          lz;
    logic [DW-1:0] dat;
    logic          rdy;
    logic          e_vld;
    logic [DW-1:0] e_dat;
    logic          e_stall;
    logic [CW-1:0] e_lvl;
    logic          e_ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the DEPTH=2 instance with scoreboard push/pop.
  task automatic step2(input logic lz, input logic [DW-1:0] d, input logic rdy);
    lz2 = lz; dat2 = d; rdy2 = rdy;
    chk("lvl2_model", 64'(lvl2), 64'(q2.size()));
    if (vld2 && rdy) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb2_pop actual=%0h required=no entry", odat2);
      end else begin
        chk("sb2_order", 64'(odat2), 64'(q2.pop_front()));
      end
    end
    if (lz && !stall2) q2.push_back(d);
    tick();
  endtask

  // One cycle on the DEPTH=3 instance with scoreboard push/pop.
  task automatic step3(input logic lz, input logic [DW-1:0] d, input logic rdy);
    lz3 = lz; dat3 = d; rdy3 = rdy;
    chk("lvl3_model", 64'(lvl3), 64'(q3.size()));
    chk("lvl3_max", 64'(lvl3 <= 4'd3), 64'(1));
    if (vld3 && rdy) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb3_pop actual=%0h required=no entry", odat3);
      end else begin
        chk("sb3_order", 64'(odat3), 64'(q3.pop_front()));
      end
    end
    if (lz && !stall3) q3.push_back(d);
    tick();
  endtask

  vec_t tv[13];

  initial begin
    tv[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0,         1'b0, 4'd0, 1'b0};
    tv[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 4'd1, 1'b0};
    tv[2]  = '{1'b1, 32'h11,        1'b0, 1'b0, 32'h0,         1'b0, 4'd0, 1'b0};
    tv[3]  = '{1'b1, 32'h22,        1'b0, 1'b1, 32'h11,        1'b0, 4'd1, 1'b0};
    tv[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h11,        1'b1, 4'd2, 1'b0};
    tv[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h11,        1'b1, 4'd2, 1'b0};
    tv[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h22,        1'b0, 4'd1, 1'b0};
    tv[7]  = '{1'b1, 32'hAA,        1'b0, 1'b0, 32'h0,         1'b0, 4'd0, 1'b0};
    tv[8]  = '{1'b1, 32'hBB,        1'b0, 1'b1, 32'hAA,        1'b0, 4'd1, 1'b0};
    tv[9]  = '{1'b1, 32'hDEAD,      1'b0, 1'b1, 32'hAA,        1'b1, 4'd2, 1'b0};
    tv[10] = '{1'b1, 32'hDEAD,      1'b1, 1'b1, 32'hAA,        1'b1, 4'd2, OVF_EN};
    tv[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hBB,        1'b0, 4'd1, OVF_EN};
    tv[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 4'd0, OVF_EN};

    tick();
    tick();
    rst_n = 1'b1;

    // Single push, fill/stall/drain, and strobes against a full FIFO.
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("row%0d_vld", i),   64'(vld2),   64'(tv[i].e_vld));
      chk($sformatf("row%0d_dat", i),   64'(odat2),  64'(tv[i].e_dat));
      chk($sformatf("row%0d_stall", i), 64'(stall2), 64'(tv[i].e_stall));
      chk($sformatf("row%0d_lvl", i),   64'(lvl2),   64'(tv[i].e_lvl));
      chk($sformatf("row%0d_ovf", i),   64'(ovf2),   64'(tv[i].e_ovf));
      lz2 = tv[i].lz; dat2 = tv[i].dat; rdy2 = tv[i].rdy;
      tick();
    end

    // Steady push+pop every cycle from level 1; pointers wrap repeatedly.
    step2(1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("steady_lvl", 64'(lvl2), 64'(1));
      step2(1'b1, DW'(i + 1), 1'b1);
    end
    step2(1'b0, '0, 1'b1);
    chk("steady_end_vld", 64'(vld2), 64'(0));
    chk("steady_end_sb", 64'(q2.size()), 64'(0));
    chk("steady_ovf", 64'(ovf2), 64'(OVF_EN));

    // Reset asserted mid-cycle with two entries held.
    step2(1'b1, 32'h44, 1'b0);
    step2(1'b1, 32'h55, 1'b0);
    chk("pre_rst_lvl", 64'(lvl2), 64'(2));
    chk("pre_rst_stall", 64'(stall2), 64'(1));
    lz2 = 1'b0; rdy2 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_vld", 64'(vld2), 64'(0));
    chk("rst_stall", 64'(stall2), 64'(0));
    chk("rst_lvl", 64'(lvl2), 64'(0));
    chk("rst_dat", 64'(odat2), 64'(0));
    chk("rst_ovf", 64'(ovf2), 64'(0));
    q2.delete();
    tick();
    tick();
    rst_n = 1'b1;
    step2(1'b1, 32'h33, 1'b0);
    chk("post_rst_vld", 64'(vld2), 64'(1));
    chk("post_rst_dat", 64'(odat2), 64'(32'h33));
    chk("post_rst_lvl", 64'(lvl2), 64'(1));
    step2(1'b0, '0, 1'b1);
    chk("post_rst_empty", 64'(vld2), 64'(0));

    // DEPTH=3 with random out_rdy; legal strobes only.
    for (int i = 0; i < 40; i++) begin
      logic lz;
      lz = !stall3 && ((i % 4) != 3);
      step3(lz, DW'(32'h300 + i), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 8 && vld3; k++) begin
      step3(1'b0, '0, 1'b1);
    end
    chk("d3_drain_vld", 64'(vld3), 64'(0));
    chk("d3_drain_sb", 64'(q3.size()), 64'(0));
    chk("d3_drain_lvl", 64'(lvl3), 64'(0));
    chk("d3_ovf", 64'(ovf3), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
